alu_seq_exec: RTL and testbench
===============================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have ports: i_clk input 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have i_rst input 1, synchronous, active-high reset.
REQ-003 SHALL have i_valid input 1, upstream operation request.
REQ-004 SHALL have o_ready output 1, block can accept an operation this cycle.
REQ-005 SHALL have i_opsel input 3, operation select: 000 add/sub, 001 SLL, 010 pass op2, 011 SLT, 100 XOR, 101 shift right, 110 OR, 111 AND.
REQ-006 SHALL have i_sub, i_unsigned and i_arith as 1-bit inputs: subtract, unsigned compare, and arithmetic right shift respectively.
REQ-007 SHALL have i_op1 and i_op2 as 32-bit inputs, operands A and B.
REQ-008 SHALL have o_valid output 1, result available.
REQ-009 SHALL have i_ready input 1, downstream accepts result.
REQ-010 SHALL have o_result output 32, operation result.
REQ-011 SHALL have o_eq output 1, registered (op1 == op2).
REQ-012 SHALL have o_lt output 1, registered op1 < op2, signed or unsigned per i_unsigned.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; o_ready = (state == IDLE); o_valid = (state == DONE).
REQ-014 SHALL accept on i_valid && o_ready; all inputs latched at accept; input changes after accept ignored until next accept.
REQ-015 SHALL, at accept with i_opsel not in {001, 101}, register the full result, o_eq and o_lt, and enter DONE (o_valid high in the cycle after accept).
REQ-016 SHALL compute add/sub as i_op1 +/- i_op2 modulo 2^32 (i_sub selects); 010 yields i_op2; 011 yields {31'b0, lt}.
REQ-017 SHALL, at accept of a shift, load the shift register with i_op1 and the counter with i_op2[4:0]; upper bits of op2 ignored.
REQ-018 SHALL enter DONE directly for a shift amount of 0 (result = i_op1, latency 1), else enter SHIFT.
REQ-019 SHALL, in SHIFT, shift exactly one bit per cycle: left zero-fill (001); right zero-fill, or sign-fill when latched i_arith = 1 (101); counter decrements by 1.
REQ-020 SHALL leave SHIFT for DONE on the cycle the counter goes 1 -> 0; a shift by n gives o_valid n+1 cycles after the accept cycle (max 32).
REQ-021 SHALL hold o_result, o_eq and o_lt stable while o_valid && !i_ready.
REQ-022 SHALL return to IDLE on o_valid && i_ready; no accept in that same cycle (o_ready low in DONE).
REQ-023 SHALL compute o_eq and o_lt for all opsel values from the latched operands.
REQ-024 SHALL ignore i_sub for non-000 opsel, i_arith for non-101 opsel, and i_unsigned for non-011 opsel except when forming o_lt.

Reset
REQ-025 SHALL, on i_rst, enter IDLE and clear o_result, o_eq, o_lt, the counter and latched controls to 0; o_valid = 0 and o_ready = 1 in the first cycle after reset.
REQ-026 SHALL, on i_rst during SHIFT or DONE, abandon the operation with no o_valid for it.
REQ-027 SHALL give i_rst priority over i_valid and i_ready in the same cycle.

Structure
REQ-028 SHALL take opsel encodings (OPSEL_ADD ... OPSEL_AND) and state encodings from shared header alu_defs.vh, also used by the ALU control decoder.
REQ-029 SHALL place non-shift combinational datapath (add/sub, logic, compare, pass) in sub-module alu_comb; shift sequencing, FSM and handshake stay in alu_seq_exec.

Verification
REQ-030 SHALL check ADD: op1=0x0000_0005, op2=0x0000_0003, opsel=000, sub=0 -> o_result=0x0000_0008 with o_valid 1 cycle after accept; sub=1 -> 0x0000_0002; 0xFFFF_FFFF+1 -> 0x0000_0000.
REQ-031 SHALL check SRA: op1=0x8000_0000, op2=0x0000_0004, opsel=101, arith=1 -> 0xF800_0000 after 5 cycles; arith=0 -> 0x0800_0000; op2=0x0000_0020 (shamt 0) -> 0x8000_0000 after 1 cycle.
REQ-032 SHALL check SLT/SLTU: op1=0xFFFF_FFFF, op2=0x0000_0001, opsel=011 -> signed o_result=1 and o_lt=1; unsigned o_result=0 and o_lt=0; o_eq=0 in both.
REQ-033 SHALL check backpressure: SLL op1=0x1, op2=31 with i_ready held low 10 cycles -> o_result=0x8000_0000 held stable, o_ready=0 throughout; release -> IDLE the next cycle.
REQ-034 SHALL check reset mid-shift: i_rst asserted in the 3rd SHIFT cycle -> next cycle o_valid=0, o_ready=1, o_result=0, and no stale o_valid afterwards.
REQ-035 SHALL check latching: changing i_op1 and i_opsel during SHIFT does not alter the result of the in-flight operation.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// Shared encodings for the sequential ALU: operation selects and FSM states.
package alu_seq_exec_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSll  = 3'b001,
    OpPass = 3'b010,
    OpSlt  = 3'b011,
    OpXor  = 3'b100,
    OpSr   = 3'b101,
    OpOr   = 3'b110,
    OpAnd  = 3'b111
  } opsel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  function automatic logic is_shift(logic [2:0] opsel);
    return (opsel == OpSll) || (opsel == OpSr);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub, logic ops, compare and pass-through.
module alu_comb
  import alu_seq_exec_pkg::*;
(
  input  logic [2:0]  i_opsel,
  input  logic        i_sub,
  input  logic        i_unsigned,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_lt
);

  logic [31:0] sum;

  assign sum  = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
  assign o_eq = (i_op1 == i_op2);
  assign o_lt = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));

  always_comb begin
    o_result = 32'h0;
    unique case (opsel_e'(i_opsel))
      OpAdd:  o_result = sum;
      OpPass: o_result = i_op2;
      OpSlt:  o_result = {31'b0, o_lt};
      OpXor:  o_result = i_op1 ^ i_op2;
      OpOr:   o_result = i_op1 | i_op2;
      OpAnd:  o_result = i_op1 & i_op2;
      // Shifts are sequenced by the parent; nothing to produce here.
      OpSll, OpSr: o_result = 32'h0;
      default: o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle ops via alu_comb, one-bit-per-cycle shifts,
// valid/ready handshake on both sides.
module alu_seq_exec
  import alu_seq_exec_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_opsel,
  input  logic        i_sub,
  input  logic        i_unsigned,
  input  logic        i_arith,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_lt
);

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        eq_q, eq_d, lt_q, lt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d, arith_q, arith_d;

  logic [31:0] comb_result;
  logic        comb_eq, comb_lt;

  alu_comb u_alu_comb (
    .i_opsel    (i_opsel),
    .i_sub      (i_sub),
    .i_unsigned (i_unsigned),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .o_result   (comb_result),
    .o_eq       (comb_eq),
    .o_lt       (comb_lt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      result_q <= 32'h0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          eq_d = comb_eq;
          lt_d = comb_lt;
          if (is_shift(i_opsel)) begin
            // result_q doubles as the shift register while in StShift.
            result_d = i_op1;
            cnt_d    = i_op2[4:0];
            left_d   = (i_opsel == OpSll);
            arith_d  = i_arith & (i_opsel == OpSr);
            state_d  = (i_op2[4:0] == 5'd0) ? StDone : StShift;
          end else begin
            result_d = comb_result;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        if (left_q) begin
          result_d = {result_q[30:0], 1'b0};
        end else begin
          result_d = {arith_q & result_q[31], result_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ready  = (state_q == StIdle);
  assign o_valid  = (state_q == StDone);
  assign o_result = result_q;
  assign o_eq     = eq_q;
  assign o_lt     = lt_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec.
module tb_alu_seq_exec;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_opsel;
  logic        i_sub;
  logic        i_unsigned;
  logic        i_arith;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_eq;
  logic        o_lt;

  int total = 0;
  int bad   = 0;

  alu_seq_exec dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_opsel    (i_opsel),
    .i_sub      (i_sub),
    .i_unsigned (i_unsigned),
    .i_arith    (i_arith),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_eq       (o_eq),
    .o_lt       (o_lt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one operation and returns just after its accept edge.
  task automatic start(input logic [2:0] opsel, input logic sub, input logic uns,
                       input logic arith, input logic [31:0] op1, input logic [31:0] op2);
    check("ready_before_accept", {31'b0, o_ready}, 32'd1);
    i_opsel    = opsel;
    i_sub      = sub;
    i_unsigned = uns;
    i_arith    = arith;
    i_op1      = op1;
    i_op2      = op2;
    i_valid    = 1'b1;
    tick();
    i_valid    = 1'b0;
  endtask

  // Cycles from the accept cycle until o_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("idle_after_drain", {30'b0, o_ready, o_valid}, 32'b10);
  endtask

  task automatic run_op(input string tag, input logic [2:0] opsel, input logic sub,
                        input logic uns, input logic arith, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_eq, input logic exp_lt);
    int lat;
    start(opsel, sub, uns, arith, op1, op2);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, o_result, exp_res);
    check({tag, "_eqlt"}, {30'b0, o_eq, o_lt}, {30'b0, exp_eq, exp_lt});
    drain();
  endtask

  initial begin
    int lat;
    int seen;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_opsel = 3'b0; i_sub = 1'b0; i_unsigned = 1'b0; i_arith = 1'b0;
    i_op1 = 32'h0; i_op2 = 32'h0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    check("reset_state", {28'b0, o_ready, o_valid, o_eq, o_lt}, 32'b1000);
    check("reset_result", o_result, 32'h0);

    //     tag          opsel   sub   uns   arith op1           op2           result        lat eq    lt
    run_op("add",       3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1, 1'b0, 1'b0);
    run_op("sub",       3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1, 1'b0, 1'b0);
    run_op("add_wrap",  3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0, 1'b1);
    run_op("sra",       3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5, 1'b0, 1'b1);
    run_op("srl",       3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5, 1'b0, 1'b1);
    run_op("sr_zero",   3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1, 1'b0, 1'b1);
    run_op("slt",       3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0, 1'b1);
    run_op("sltu",      3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0, 1'b0);
    run_op("xor_eq",    3'b100, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1, 1'b1, 1'b0);
    run_op("or",        3'b110, 1'b0, 1'b0, 1'b0, 32'hF000_000F, 32'h0000_FF00, 32'hF000_FF0F, 1, 1'b0, 1'b1);
    run_op("and",       3'b111, 1'b0, 1'b1, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b0, 1'b0);
    run_op("pass",      3'b010, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    run_op("sll1",      3'b001, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 2, 1'b0, 1'b0);

    // Backpressure: result must hold while downstream stalls.
    start(3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd31);
    wait_valid(lat);
    check("bp_lat", lat, 32);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_res", o_result, 32'h8000_0000);
      check("bp_hold_hs", {30'b0, o_ready, o_valid}, 32'b01);
      tick();
    end
    drain();

    // Latching: in-flight shift ignores input changes.
    start(3'b101, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0004);
    i_op1 = 32'h0; i_opsel = 3'b000; i_op2 = 32'h0; i_arith = 1'b1;
    wait_valid(lat);
    check("latch_lat", lat, 5);
    check("latch_res", o_result, 32'h0000_000F);
    drain();

    // Reset in the third SHIFT cycle abandons the operation.
    start(3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd10);
    tick();
    tick();
    check("mid_in_shift", {30'b0, o_ready, o_valid}, 32'b00);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_hs", {30'b0, o_ready, o_valid}, 32'b10);
    check("rst_res", o_result, 32'h0);
    seen = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_valid) seen++;
    end
    i_ready = 1'b0;
    check("no_stale_valid", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
